// File: rtl/tlul_mem_responder.sv
// TL-UL device-side memory responder: accepts Get/PutFullData/PutPartialData on A and returns
// in-order AccessAck(Data) on D after a configurable latency, with a bounded in-flight depth.
package tlul_pkg;
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef logic [13:0] tl_user_t;
  localparam tl_user_t TL_D_USER_DEFAULT = '0;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_user_t    a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_user_t    d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_mem_responder
  import tlul_pkg::*;
#(
  parameter int unsigned Depth       = 1024,
  parameter int unsigned Latency     = 0,
  parameter int unsigned Outstanding = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  tl_h2d_t                          tl_i,
  output tl_d2h_t                          tl_o,
  output logic [$clog2(Outstanding+1)-1:0] outstanding_o
);
  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
  localparam int unsigned CW = $clog2(Outstanding + 1);

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [7:0]  source;
    logic [31:0] data;
    logic        error;
  } entry_t;

  logic [31:0]   mem   [Depth];
  entry_t        ent_q [Outstanding];
  logic [3:0]    cnt_q [Outstanding];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  logic          d_valid, retire, a_ready, accept;
  logic          is_get, is_put, misaligned, req_err;
  logic [3:0]    size_mask, need_mask;
  logic [AW-1:0] word_idx;
  entry_t        new_ent;
  logic          unused_fields;

  assign unused_fields = ^{tl_i.a_param, tl_i.a_user};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Outstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  assign word_idx = tl_i.a_address[AW+1:2];
  assign d_valid  = (count_q != '0) && (cnt_q[rptr_q] == '0);
  assign retire   = d_valid & tl_i.d_ready;
  // A retiring head frees its slot in the same cycle, so a full queue can still accept.
  assign a_ready  = rst_ni & ((count_q < CW'(Outstanding)) | retire);
  assign accept   = tl_i.a_valid & a_ready;

  always_comb begin
    is_get = (tl_i.a_opcode == Get);
    is_put = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    case (tl_i.a_size)
      2'd0: begin
        size_mask  = 4'b0001;
        misaligned = 1'b0;
      end
      2'd1: begin
        size_mask  = 4'b0011;
        misaligned = tl_i.a_address[0];
      end
      default: begin
        size_mask  = 4'b1111;
        misaligned = (tl_i.a_address[1:0] != 2'b00);
      end
    endcase
    need_mask = size_mask << tl_i.a_address[1:0];
    req_err = (tl_i.a_address[31:2] >= 30'(Depth)) || (tl_i.a_size > 2'd2) || misaligned ||
              !(is_get || is_put) ||
              ((tl_i.a_opcode == PutFullData) && ((tl_i.a_mask & need_mask) != need_mask));
    new_ent.opcode = tl_i.a_opcode;
    new_ent.size   = tl_i.a_size;
    new_ent.source = tl_i.a_source;
    new_ent.error  = req_err;
    new_ent.data   = (is_get && !req_err) ? mem[word_idx] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (accept && is_put && !req_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (tl_i.a_mask[i]) mem[word_idx][8*i +: 8] <= tl_i.a_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < Outstanding; i++) begin
        ent_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < Outstanding; i++) begin
        if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 4'd1;
      end
      if (accept) begin
        ent_q[wptr_q] <= new_ent;
        cnt_q[wptr_q] <= 4'(Latency);
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (retire) rptr_q <= ptr_inc(rptr_q);
      count_q <= count_q + CW'(accept) - CW'(retire);
    end
  end

  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = a_ready;
    if (d_valid) begin
      tl_o.d_valid  = 1'b1;
      tl_o.d_opcode = (ent_q[rptr_q].opcode == Get) ? AccessAckData : AccessAck;
      tl_o.d_size   = ent_q[rptr_q].size;
      tl_o.d_source = ent_q[rptr_q].source;
      tl_o.d_data   = ent_q[rptr_q].data;
      tl_o.d_error  = ent_q[rptr_q].error;
      tl_o.d_user   = TL_D_USER_DEFAULT;
    end
  end

  assign outstanding_o = count_q;
endmodule

// File: tb/tb_tlul_mem_responder.sv
// Bench for tlul_mem_responder: two instances (Latency 0 / Outstanding 2, Latency 3 / Outstanding 3)
// driven by directed and random A/D traffic, checked against a transaction-level response model.
module tb_tlul_mem_responder;
  import tlul_pkg::*;

  localparam int N = 2;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  tl_h2d_t h2d [N];
  tl_d2h_t d2h [N];
  logic [1:0] occ [N];

  always #5 clk = ~clk;

  tlul_mem_responder #(.Depth(1024), .Latency(0), .Outstanding(2)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .tl_i(h2d[0]), .tl_o(d2h[0]), .outstanding_o(occ[0]));
  tlul_mem_responder #(.Depth(64), .Latency(3), .Outstanding(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .tl_i(h2d[1]), .tl_o(d2h[1]), .outstanding_o(occ[1]));

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] data;
    bit          known;
    bit          err;
    int unsigned due;
  } rsp_t;

  rsp_t        exp_q [N][$];
  logic [31:0] mdl_mem [N][1024];
  logic [3:0]  mdl_kb  [N][1024];
  bit          acc_flag [N];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  function automatic int unsigned lat_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction
  function automatic int unsigned outs_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction
  function automatic int unsigned depth_of(input int k);
    return (k == 0) ? 1024 : 64;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit req_error(input int k, input tl_h2d_t r);
    int unsigned bytes, off;
    bytes = 1 << r.a_size;
    off   = r.a_address % 4;
    if ((r.a_address >> 2) >= depth_of(k)) return 1;
    if (r.a_size > 2) return 1;
    if ((r.a_address % bytes) != 0) return 1;
    if (!(r.a_opcode inside {3'd0, 3'd1, 3'd4})) return 1;
    if (r.a_opcode == 3'd0)
      for (int unsigned i = off; i < off + bytes; i++) if (i < 4 && !r.a_mask[i]) return 1;
    return 0;
  endfunction

  task automatic model_accept(input int k);
    rsp_t        r;
    tl_h2d_t     q;
    int unsigned word;
    q       = h2d[k];
    word    = q.a_address >> 2;
    r.op    = q.a_opcode;
    r.size  = q.a_size;
    r.src   = q.a_source;
    r.err   = req_error(k, q);
    r.due   = cyc + 1 + lat_of(k);
    r.data  = '0;
    r.known = r.err;
    if (!r.err && q.a_opcode == 3'd4) begin
      r.data  = mdl_mem[k][word];
      r.known = (mdl_kb[k][word] == 4'hF);
    end
    if (!r.err && q.a_opcode inside {3'd0, 3'd1}) begin
      for (int i = 0; i < 4; i++) begin
        if (q.a_mask[i]) begin
          mdl_mem[k][word][8*i +: 8] = q.a_data[8*i +: 8];
          mdl_kb[k][word][i] = 1'b1;
        end
      end
    end
    exp_q[k].push_back(r);
  endtask

  task automatic eval(input int k);
    bit   exp_dv, exp_rdy, ret;
    rsp_t h;
    string p;
    p = $sformatf("d%0d_", k);
    if (!rst_n) exp_q[k].delete();
    exp_dv = 1'b0;
    if (rst_n && exp_q[k].size() > 0) begin
      h = exp_q[k][0];
      exp_dv = (cyc >= h.due);
    end
    ret     = exp_dv && h2d[k].d_ready;
    exp_rdy = rst_n && ((exp_q[k].size() < outs_of(k)) || ret);
    check({p, "a_ready"}, d2h[k].a_ready, exp_rdy);
    check({p, "d_valid"}, d2h[k].d_valid, exp_dv);
    check({p, "outstanding"}, occ[k], 64'(exp_q[k].size()));
    if (!rst_n)
      check({p, "reset_d_fields"}, {d2h[k].d_opcode, d2h[k].d_param, d2h[k].d_size, d2h[k].d_source,
            d2h[k].d_sink, d2h[k].d_data, d2h[k].d_user, d2h[k].d_error}, 64'd0);
    if (exp_dv) begin
      check({p, "d_opcode"}, d2h[k].d_opcode, (h.op == 3'd4) ? 3'd1 : 3'd0);
      check({p, "d_size"}, d2h[k].d_size, h.size);
      check({p, "d_source"}, d2h[k].d_source, h.src);
      check({p, "d_error"}, d2h[k].d_error, h.err);
      check({p, "d_param_sink"}, {d2h[k].d_param, d2h[k].d_sink}, 4'd0);
      check({p, "d_user"}, d2h[k].d_user, TL_D_USER_DEFAULT);
      if (h.known) check({p, "d_data"}, d2h[k].d_data, h.data);
    end
    if (ret) void'(exp_q[k].pop_front());
    acc_flag[k] = h2d[k].a_valid && exp_rdy;
    if (acc_flag[k]) model_accept(k);
  endtask

  task automatic cycle();
    #1;
    for (int k = 0; k < N; k++) eval(k);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input int k, input logic [2:0] op, input logic [31:0] addr,
                      input logic [1:0] size, input logic [3:0] mask, input logic [31:0] data);
    bit done;
    done = 1'b0;
    h2d[k].a_valid   = 1'b1;
    h2d[k].a_opcode  = op;
    h2d[k].a_address = addr;
    h2d[k].a_size    = size;
    h2d[k].a_mask    = mask;
    h2d[k].a_data    = data;
    h2d[k].a_source  = 8'($urandom);
    for (int i = 0; i < 40 && !done; i++) begin
      cycle();
      done = acc_flag[k];
    end
    h2d[k].a_valid = 1'b0;
    check($sformatf("d%0d_send_accepted", k), done, 1'b1);
  endtask

  task automatic wait_idle(input int k);
    h2d[k].d_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q[k].size() > 0; i++) cycle();
    check($sformatf("d%0d_drained", k), occ[k], 2'd0);
  endtask

  function automatic tl_h2d_t rand_req(input int k);
    tl_h2d_t     r;
    int unsigned sel, word, off;
    r = '0;
    r.a_valid = 1'b1;
    sel = $urandom_range(0, 9);
    r.a_opcode = (sel < 4) ? 3'd4 : (sel < 6) ? 3'd0 : (sel < 8) ? 3'd1 : 3'($urandom_range(0, 7));
    r.a_size = $urandom_range(0, 1) ? 2'd2 : 2'($urandom_range(0, 3));
    word = $urandom_range(0, 15);
    if ($urandom_range(0, 15) == 0) word = depth_of(k) + $urandom_range(0, 3);
    off = $urandom_range(0, 3);
    if ($urandom_range(0, 3) != 0) off = off & ~((32'd1 << r.a_size) - 1);
    r.a_address = word * 4 + off;
    r.a_mask = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
    r.a_data = $urandom;
    r.a_source = 8'($urandom);
    return r;
  endfunction

  initial begin
    for (int k = 0; k < N; k++) begin
      h2d[k] = '0;
      acc_flag[k] = 1'b0;
      for (int w = 0; w < 1024; w++) mdl_kb[k][w] = 4'h0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // Known contents for the low words of both memories
    for (int k = 0; k < N; k++) begin
      h2d[k].d_ready = 1'b1;
      for (int w = 0; w < 16; w++) send(k, PutFullData, 32'(w * 4), 2'd2, 4'hF, $urandom);
      wait_idle(k);
    end

    // Full write then read-back, partial byte write
    send(0, PutFullData, 32'h10, 2'd2, 4'hF, 32'hDEADBEEF);
    send(0, Get, 32'h10, 2'd2, 4'hF, 32'h0);
    wait_idle(0);
    check("t2_model_word", mdl_mem[0][4], 32'hDEADBEEF);
    send(0, PutFullData, 32'h20, 2'd2, 4'hF, 32'h11223344);
    send(0, PutPartialData, 32'h20, 2'd2, 4'h2, 32'h0000AA00);
    send(0, Get, 32'h20, 2'd2, 4'hF, 32'h0);
    wait_idle(0);

    // Latency 3 with a stalled head
    h2d[1].d_ready = 1'b0;
    send(1, Get, 32'h8, 2'd2, 4'hF, 32'h0);
    repeat (8) cycle();
    wait_idle(1);

    // Outstanding limit, accept on the retiring cycle
    h2d[0].d_ready = 1'b0;
    send(0, Get, 32'h10, 2'd2, 4'hF, 32'h0);
    send(0, Get, 32'h20, 2'd2, 4'hF, 32'h0);
    h2d[0].a_valid = 1'b1;
    h2d[0].a_opcode = Get;
    h2d[0].a_address = 32'h4;
    repeat (2) cycle();
    h2d[0].d_ready = 1'b1;
    cycle();
    h2d[0].a_valid = 1'b0;
    h2d[0].d_ready = 1'b0;
    cycle();
    wait_idle(0);

    // Error cases leave memory untouched
    send(0, Get, 32'(1024 * 4), 2'd2, 4'hF, 32'h0);
    send(0, Get, 32'h2, 2'd2, 4'hF, 32'h0);
    send(0, 3'd3, 32'h10, 2'd2, 4'hF, 32'h55555555);
    send(0, PutFullData, 32'h10, 2'd2, 4'h7, 32'h66666666);
    send(0, PutFullData, 32'h12, 2'd2, 4'hF, 32'h77777777);
    send(0, Get, 32'h10, 2'd2, 4'hF, 32'h0);
    send(0, Get, 32'h20, 2'd2, 4'hF, 32'h0);
    wait_idle(0);

    // Reset with pending responses: none may appear afterwards
    h2d[0].d_ready = 1'b0;
    send(0, Get, 32'h10, 2'd2, 4'hF, 32'h0);
    send(0, Get, 32'h20, 2'd2, 4'hF, 32'h0);
    rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    h2d[0].d_ready = 1'b1;
    repeat (5) cycle();
    send(0, Get, 32'h20, 2'd2, 4'hF, 32'h0);
    wait_idle(0);

    // Random traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < N; k++) begin
        if (!h2d[k].a_valid || acc_flag[k]) begin
          if ($urandom_range(0, 1) != 0) h2d[k] = rand_req(k);
          else h2d[k].a_valid = 1'b0;
        end
        h2d[k].d_ready = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end
    for (int k = 0; k < N; k++) h2d[k].a_valid = 1'b0;
    wait_idle(0);
    wait_idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
